// File: rtl/reg_file.sv
// Two-read/one-write register file with a pending-write scoreboard.
// Reads are registered, same-cycle writeback data is forwarded, and reads of pending registers stall.
module reg_file #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 16
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              reg_a_read,
    input  logic [3:0]        reg_a,
    input  logic              reg_b_read,
    input  logic [3:0]        reg_b,
    output logic [DATA_W-1:0] reg_a_value,
    output logic [DATA_W-1:0] reg_b_value,
    output logic              stall,
    input  logic              lock_en,
    input  logic [3:0]        lock_reg,
    input  logic              wr_en,
    input  logic [3:0]        wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    output logic [15:0]       busy
);

    logic [DATA_W-1:0] r_regs [REG_COUNT];
    logic [15:0]       r_busy;
    logic [DATA_W-1:0] r_a_value;
    logic [DATA_W-1:0] r_b_value;

    logic              w_hit_a;
    logic              w_hit_b;
    logic              w_blk_a;
    logic              w_blk_b;
    logic              w_stall;
    logic [DATA_W-1:0] w_a_data;
    logic [DATA_W-1:0] w_b_data;
    logic [15:0]       w_busy_next;

    always_comb begin
        w_hit_a = wr_en && (wr_reg == reg_a);
        w_hit_b = wr_en && (wr_reg == reg_b);

        // A same-cycle writeback to a pending register releases it immediately.
        w_blk_a = reg_a_read && r_busy[reg_a] && !w_hit_a;
        w_blk_b = reg_b_read && r_busy[reg_b] && !w_hit_b;
        w_stall = w_blk_a || w_blk_b;

        w_a_data = '0;
        if (w_hit_a)
            w_a_data = wr_data;
        else if (32'(reg_a) < REG_COUNT)
            w_a_data = r_regs[reg_a];

        w_b_data = '0;
        if (w_hit_b)
            w_b_data = wr_data;
        else if (32'(reg_b) < REG_COUNT)
            w_b_data = r_regs[reg_b];

        // Lock is applied after the clear so a colliding lock leaves the register pending.
        w_busy_next = r_busy;
        if (wr_en)
            w_busy_next[wr_reg] = 1'b0;
        if (lock_en)
            w_busy_next[lock_reg] = 1'b1;
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            for (int unsigned i = 0; i < unsigned'(REG_COUNT); i++)
                r_regs[i] <= '0;
            r_busy    <= '0;
            r_a_value <= '0;
            r_b_value <= '0;
        end else begin
            if (wr_en && (32'(wr_reg) < REG_COUNT))
                r_regs[wr_reg] <= wr_data;
            r_busy <= w_busy_next;
            if (!w_stall) begin
                if (reg_a_read)
                    r_a_value <= w_a_data;
                if (reg_b_read)
                    r_b_value <= w_b_data;
            end
        end
    end

    assign reg_a_value = r_a_value;
    assign reg_b_value = r_b_value;
    assign stall       = w_stall;
    assign busy        = r_busy;

endmodule

// File: doc/reg_file.md
# reg_file

Two-read/one-write register file with a pending-write scoreboard, serving the operand read requests issued by the `read` pipeline stage. Each cycle it samples the stage's `reg_a_read`/`reg_a` and `reg_b_read`/`reg_b` requests and returns registered `reg_a_value`/`reg_b_value` one cycle later. It also accepts writeback results and tracks registers whose results are still in flight, so it can stall reads that would otherwise return stale data. It sits between the `read` stage (requester) and the writeback stage (writer).

## Interface

Parameters:
- `DATA_W`, 16, register width; must match `reg_a_value`/`reg_b_value` of `read`.
- `REG_COUNT`, 16, number of registers; index width fixed at 4 bits.

Ports:
- `cpu_clk`  in  1  sole clock; all state updates on the rising edge.
- `cpu_rst`  in  1  synchronous, active-high reset, sampled on the `cpu_clk` rising edge.
- `reg_a_read`  in  1  port A read request.
- `reg_a`  in  4  port A register index.
- `reg_b_read`  in  1  port B read request.
- `reg_b`  in  4  port B register index.
- `reg_a_value`  out  DATA_W  port A read data (registered).
- `reg_b_value`  out  DATA_W  port B read data (registered).
- `stall`  out  1  combinational; at least one active request targets a pending register.
- `lock_en`  in  1  mark `lock_reg` as pending (result in flight).
- `lock_reg`  in  4  register to mark pending.
- `wr_en`  in  1  writeback strobe.
- `wr_reg`  in  4  writeback destination.
- `wr_data`  in  DATA_W  writeback data.
- `busy`  out  16  scoreboard vector; bit i = register i pending (registered).

## Operation

Storage:
- `REG_COUNT` × `DATA_W` registers. All are writable; there is no hardwired zero register.

Scoreboard:
- On `lock_en`, set `busy[lock_reg]` at the next edge.
- On `wr_en`, clear `busy[wr_reg]` and write `wr_data` at the next edge.
- If `lock_en` and `wr_en` target the same register in one cycle: data is written and busy ends **set**, because the new lock wins.
- `wr_en` to a non-busy register is legal: data is written, busy stays 0.

Stall:
- Port X is *blocked* when `reg_x_read` = 1, `busy[reg_x]` = 1, and not (`wr_en` && `wr_reg` == `reg_x`).
- `stall` = blocked_A | blocked_B.
- `stall` is computed from the busy state before the current cycle's lock; a same-cycle `lock_en` does not stall a same-cycle read.

Read data:
- On each edge with `reg_x_read` = 1 and `stall` = 0, `reg_x_value` loads the data for `reg_x`.
- Forwarding: if `wr_en` && `wr_reg` == `reg_x`, the loaded value is `wr_data`; otherwise it is the stored register.
- When `stall` = 1, both value registers hold, including a non-blocked port. The requester must hold its requests until `stall` drops.
- With `reg_x_read` = 0, `reg_x_value` holds its previous value.
- Ports A and B may read the same index; both receive identical data.

Reset:
- The synchronous reset clears all registers, `busy`, `reg_a_value` and `reg_b_value` to 0.
- `stall` is 0 because `busy` is 0.
- Reset overrides any simultaneous lock, write or read. Any mid-operation state is discarded; locks in flight are lost.

## Timing

- Read latency is 1 cycle: a request accepted at edge N shows data after edge N, valid for the whole cycle N+1.
- Write-to-read, same cycle: forwarded. A write at edge N to register r with a simultaneous read of r gives `wr_data` in cycle N+1.
- Write then read in the next cycle: served from storage.
- Lock at edge N: `busy` is visible from cycle N+1. A read of the same register in cycle N+1 stalls.
- `stall` is combinational from the inputs and `busy`, with no registered delay. It drops in the same cycle as the clearing `wr_en`.
- Throughput: one read per port per cycle when not stalled.

## Test plan

- **Reset:** write r3 = 0x1234, assert `cpu_rst` for 1 cycle, read r3 on A.
  → `reg_a_value` = 0x0000, `busy` = 0x0000, `stall` = 0.
- **Basic read/write:** write r5 = 0xBEEF; next cycle read A = r5, B = r5.
  → both values = 0xBEEF one cycle later.
- **Forwarding:** same cycle `wr_en` r7 = 0xA5A5 and read A = r7 (r7 previously 0x0001).
  → `reg_a_value` = 0xA5A5 next cycle, `stall` = 0.
- **Scoreboard stall:**
  - Lock r2 at edge N; in cycle N+1 read B = r2 and A = r4 (r4 = 0x0004).
    → `stall` = 1, and `reg_a_value` and `reg_b_value` hold their prior values.
  - Cycle N+3: `wr_en` r2 = 0x0022 with the read still held.
    → `stall` = 0 in that cycle; next cycle B = 0x0022, A = 0x0004, `busy[2]` = 0.
- **Lock and write collide:** `busy[9]` = 1, same cycle `lock_en` r9 and `wr_en` r9 = 0x0909.
  → next cycle `busy[9]` = 1, and a read of r9 stalls; after a later `wr_en` r9 = 0x0999, the read returns 0x0999.
- **Idle hold:** after reading r1 = 0x0011, drop both read strobes for 3 cycles while writing r1 = 0x0FFF.
  → `reg_a_value` stays 0x0011 throughout.
